// File: rtl/pdp1_shrot_unit.sv
// PDP-1 shift/rotate group unit (ral..scr): steps AC, IO or AC||IO one place per clock.
// Define PDP1_SHROT_FAST_EN to apply the whole count in a single barrel step instead.
module pdp1_shrot_unit #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 9,
  parameter int CW    = $clog2(CNT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op_reg,
  input  logic             op_arith,
  input  logic             op_right,
  input  logic [CNT_W-1:0] cnt,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] ac_out,
  output logic [WIDTH-1:0] io_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ac_q, ac_nxt, io_q, io_nxt;
  logic [1:0]       reg_q, reg_nxt;
  logic             arith_q, arith_nxt, right_q, right_nxt;
  logic [CW-1:0]    step_q, step_nxt, n_start;
  logic [2*WIDTH-1:0] run_step;

  function automatic logic [CW-1:0] popcount(input logic [CNT_W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < CNT_W; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Vector MSB is PDP bit 0 (sign); arithmetic shifts keep it and use it as fill.
  function automatic logic [WIDTH-1:0] step_w(input logic [WIDTH-1:0] v,
                                              input logic arith, input logic right);
    logic [WIDTH-1:0] r;
    if (!arith) r = right ? {v[0], v[WIDTH-1:1]} : {v[WIDTH-2:0], v[WIDTH-1]};
    else        r = right ? {v[WIDTH-1], v[WIDTH-1], v[WIDTH-2:1]}
                          : {v[WIDTH-1], v[WIDTH-3:0], v[WIDTH-1]};
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] step_2w(input logic [2*WIDTH-1:0] v,
                                                 input logic arith, input logic right);
    logic [2*WIDTH-1:0] r;
    if (!arith) r = right ? {v[0], v[2*WIDTH-1:1]} : {v[2*WIDTH-2:0], v[2*WIDTH-1]};
    else        r = right ? {v[2*WIDTH-1], v[2*WIDTH-1], v[2*WIDTH-2:1]}
                          : {v[2*WIDTH-1], v[2*WIDTH-3:0], v[2*WIDTH-1]};
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] step_sel(input logic [WIDTH-1:0] ac,
                                                  input logic [WIDTH-1:0] io,
                                                  input logic [1:0] sel,
                                                  input logic arith, input logic right);
    logic [2*WIDTH-1:0] r;
    r = {ac, io};
    case (sel)
      2'b01:   r[2*WIDTH-1:WIDTH] = step_w(ac, arith, right);
      2'b10:   r[WIDTH-1:0]       = step_w(io, arith, right);
      2'b11:   r                  = step_2w({ac, io}, arith, right);
      default: r                  = {ac, io};
    endcase
    return r;
  endfunction

  // The reserved register select behaves as a zero count.
  assign n_start  = (op_reg == 2'b00) ? '0 : popcount(cnt);
  assign run_step = step_sel(ac_q, io_q, reg_q, arith_q, right_q);

`ifdef PDP1_SHROT_FAST_EN
  logic [2*WIDTH-1:0] fast_res;

  always_comb begin
    fast_res = {ac_in, io_in};
    for (int i = 0; i < CNT_W; i++) begin
      if (CW'(i) < n_start)
        fast_res = step_sel(fast_res[2*WIDTH-1:WIDTH], fast_res[WIDTH-1:0],
                            op_reg, op_arith, op_right);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    ac_nxt    = ac_q;
    io_nxt    = io_q;
    reg_nxt   = reg_q;
    arith_nxt = arith_q;
    right_nxt = right_q;
    step_nxt  = step_q;
    case (state)
      IDLE: begin
        if (start) begin
          reg_nxt   = op_reg;
          arith_nxt = op_arith;
          right_nxt = op_right;
          step_nxt  = n_start;
`ifdef PDP1_SHROT_FAST_EN
          {ac_nxt, io_nxt} = fast_res;
          state_nxt        = DONE;
`else
          ac_nxt    = ac_in;
          io_nxt    = io_in;
          state_nxt = (n_start == '0) ? DONE : RUN;
`endif
        end
      end
      RUN: begin
        {ac_nxt, io_nxt} = run_step;
        step_nxt         = step_q - 1'b1;
        if (step_q == CW'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ac_q    <= '0;
      io_q    <= '0;
      reg_q   <= 2'b00;
      arith_q <= 1'b0;
      right_q <= 1'b0;
      step_q  <= '0;
    end else begin
      state   <= state_nxt;
      ac_q    <= ac_nxt;
      io_q    <= io_nxt;
      reg_q   <= reg_nxt;
      arith_q <= arith_nxt;
      right_q <= right_nxt;
      step_q  <= step_nxt;
    end
  end

  assign ac_out = ac_q;
  assign io_out = io_q;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_pdp1_shrot_unit.sv
// Directed bench for pdp1_shrot_unit: scoreboard of expected AC/IO results,
// independent shift model, latency / busy / done-pulse and reset checks.
module tb_pdp1_shrot_unit;

  localparam int WIDTH = 18;
  localparam int CNT_W = 9;
`ifdef PDP1_SHROT_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       op_reg;
  logic             op_arith;
  logic             op_right;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ac_in, io_in, ac_out, io_out;
  logic             busy, done;

  int          checks = 0;
  int          errors = 0;
  logic [35:0] sb[$];

  pdp1_shrot_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_reg(op_reg), .op_arith(op_arith),
    .op_right(op_right), .cnt(cnt), .ac_in(ac_in), .io_in(io_in),
    .ac_out(ac_out), .io_out(io_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Value occupies the low l bits; arithmetic steps split off the sign and move the magnitude.
  function automatic logic [35:0] one_step(input logic [35:0] v, input int l,
                                           input logic ar, input logic rt);
    logic [35:0] mask, mag, sgn;
    mask = (36'd1 << l) - 36'd1;
    if (!ar) begin
      if (rt) return ((v >> 1) | (v << (l - 1))) & mask;
      else    return ((v << 1) | (v >> (l - 1))) & mask;
    end
    sgn = {35'd0, v[l-1]};
    mag = v & (mask >> 1);
    if (rt) mag = (mag >> 1) | (sgn << (l - 2));
    else    mag = ((mag << 1) | sgn) & (mask >> 1);
    return (sgn << (l - 1)) | mag;
  endfunction

  function automatic logic [35:0] model(input logic [1:0] r, input logic ar, input logic rt,
                                        input int n, input logic [17:0] ac, input logic [17:0] io);
    logic [35:0] v;
    case (r)
      2'b01: begin
        v = {18'd0, ac};
        for (int k = 0; k < n; k++) v = one_step(v, 18, ar, rt);
        return {v[17:0], io};
      end
      2'b10: begin
        v = {18'd0, io};
        for (int k = 0; k < n; k++) v = one_step(v, 18, ar, rt);
        return {ac, v[17:0]};
      end
      2'b11: begin
        v = {ac, io};
        for (int k = 0; k < n; k++) v = one_step(v, 36, ar, rt);
        return v;
      end
      default: return {ac, io};
    endcase
  endfunction

  task automatic apply_stimulus(input string tag, input logic [1:0] r, input logic ar,
                                input logic rt, input logic [8:0] c,
                                input logic [17:0] ac, input logic [17:0] io,
                                input logic [35:0] exp);
    int n, lat, cyc;
    logic got;
    logic [35:0] e;
    n   = (r == 2'b00) ? 0 : $countones(c);
    lat = FAST ? 1 : n + 1;
    sb.push_back(exp);
    @(negedge clk);
    op_reg = r; op_arith = ar; op_right = rt; cnt = c; ac_in = ac; io_in = io; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_output({tag, "_busy"}, {35'd0, busy}, {35'd0, (!FAST && n > 0)});
      if (done) got = 1'b1;
    end
    check_output({tag, "_latency"}, 36'(cyc), 36'(lat));
    e = sb.pop_front();
    if (got) begin
      check_output({tag, "_result"}, {ac_out, io_out}, e);
      @(negedge clk);
      check_output({tag, "_pulse"}, {34'd0, done, busy}, 36'd0);
      check_output({tag, "_hold"}, {ac_out, io_out}, e);
    end
  endtask

  initial begin
    int dones;
    logic [35:0] res, e;
    rst_n = 1'b0; start = 1'b0; op_reg = 2'b00; op_arith = 1'b0; op_right = 1'b0;
    cnt = '0; ac_in = '0; io_in = '0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", {ac_out, io_out}, 36'd0);
    check_output("reset_flags", {34'd0, busy, done}, 36'd0);
    rst_n = 1'b1;

    apply_stimulus("ral3", 2'b01, 1'b0, 1'b0, 9'h007, 18'o000001, 18'o555555, {18'o000010, 18'o555555});
    apply_stimulus("sar9", 2'b01, 1'b1, 1'b1, 9'h1FF, 18'o400000, 18'o123456, {18'o777400, 18'o123456});
    apply_stimulus("rcr1", 2'b11, 1'b0, 1'b1, 9'h100, 18'o000001, 18'o000000, {18'o000000, 18'o400000});
    apply_stimulus("scl2", 2'b11, 1'b1, 1'b0, 9'h003, 18'o200000, 18'o600000, {18'o000003, 18'o000000});
    apply_stimulus("cnt0", 2'b01, 1'b0, 1'b1, 9'h000, 18'o654321, 18'o000017, {18'o654321, 18'o000017});
    apply_stimulus("reg00", 2'b00, 1'b1, 1'b0, 9'h1FF, 18'o123123, 18'o321321, {18'o123123, 18'o321321});
    apply_stimulus("sil9", 2'b10, 1'b1, 1'b0, 9'h1FF, 18'o000000, 18'o377777, {18'o000000, 18'o377000});
    apply_stimulus("rir4", 2'b10, 1'b0, 1'b1, 9'h0F0, 18'o707070, 18'o000017, {18'o707070, 18'o740000});
    apply_stimulus("sal2", 2'b01, 1'b1, 1'b0, 9'h011, 18'o600001, 18'o000000, {18'o400007, 18'o000000});
    apply_stimulus("scr3", 2'b11, 1'b1, 1'b1, 9'h124, 18'o400007, 18'o000000, {18'o740000, 18'o700000});
    apply_stimulus("rcl9", 2'b11, 1'b0, 1'b0, 9'h1FF, 18'o000777, 18'o000001, {18'o777000, 18'o001000});

    ac_in = 18'($urandom); io_in = 18'($urandom);
    e = {ac_in, io_in};
    apply_stimulus("rnd_sir5", 2'b10, 1'b1, 1'b1, 9'h0AB, e[35:18], e[17:0],
                   model(2'b10, 1'b1, 1'b1, 5, e[35:18], e[17:0]));
    apply_stimulus("rnd_scr7", 2'b11, 1'b1, 1'b1, 9'h07F, e[17:0], e[35:18],
                   model(2'b11, 1'b1, 1'b1, 7, e[17:0], e[35:18]));
    apply_stimulus("rnd_ril6", 2'b10, 1'b0, 1'b0, 9'h1F8, e[35:18], e[17:0],
                   model(2'b10, 1'b0, 1'b0, 6, e[35:18], e[17:0]));

    // Second start during an N=5 ril must be dropped.
    e = model(2'b01, 1'b0, 1'b0, 5, 18'o000007, 18'o111111);
    sb.push_back(e);
    @(negedge clk);
    op_reg = 2'b01; op_arith = 1'b0; op_right = 1'b0; cnt = 9'h01F;
    ac_in = 18'o000007; io_in = 18'o111111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    res = 'x;
    @(negedge clk);
    if (done) begin dones++; res = {ac_out, io_out}; end
    op_reg = 2'b11; op_arith = 1'b1; cnt = 9'h1FF; ac_in = 18'o777777; io_in = 18'o000007; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) begin dones++; res = {ac_out, io_out}; end
    end
    check_output("ignored_start_dones", 36'(dones), 36'd1);
    check_output("ignored_start_result", res, sb.pop_front());

    // Reset in the third RUN cycle of an N=8 sal.
    @(negedge clk);
    op_reg = 2'b01; op_arith = 1'b1; op_right = 1'b0; cnt = 9'h0FF;
    ac_in = 18'o012345; io_in = 18'o543210; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midrun_reset_outputs", {ac_out, io_out}, 36'd0);
    check_output("midrun_reset_flags", {34'd0, busy, done}, 36'd0);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_output("midrun_reset_no_done", 36'(dones), 36'd0);
    check_output("midrun_reset_hold", {ac_out, io_out}, 36'd0);

    check_output("scoreboard_empty", 36'(sb.size()), 36'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
